// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: write-back, issue and two read ports.
// The master drives selects and write-back data; the slave (the register file)
// returns read data, busy bits and the unreserved write-back error pulse.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16
);
    logic              writeEn;
    logic [2:0]        writeRegSel;
    logic [DATA_W-1:0] writeData;
    logic              issueEn;
    logic [2:0]        issueRegSel;
    logic [2:0]        read1RegSel;
    logic [2:0]        read2RegSel;
    logic [DATA_W-1:0] read1Data;
    logic [DATA_W-1:0] read2Data;
    logic              read1Busy;
    logic              read2Busy;
    logic              err;

    modport master (
        output writeEn, writeRegSel, writeData, issueEn, issueRegSel,
               read1RegSel, read2RegSel,
        input  read1Data, read2Data, read1Busy, read2Busy, err
    );

    modport slave (
        input  writeEn, writeRegSel, writeData, issueEn, issueRegSel,
               read1RegSel, read2RegSel,
        output read1Data, read2Data, read1Busy, read2Busy, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 8-entry register file with a busy-bit scoreboard for in-order producers.
// Issue reserves a destination, write-back commits data and releases it; a
// write-back to a register with no reservation pulses err for one cycle.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data (and the
// resulting busy state) to the read ports; without it reads see stored state.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_scoreboard_if.slave  bus
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            err_q, err_d;

    // Next state: write-back clears busy, issue sets it afterwards so a
    // same-register issue wins; err flags a write-back with no reservation.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = 1'b0;
        if (bus.writeEn) begin
            regs_d[bus.writeRegSel] = bus.writeData;
            busy_d[bus.writeRegSel] = 1'b0;
            err_d                   = !busy_q[bus.writeRegSel];
        end
        if (bus.issueEn) begin
            busy_d[bus.issueRegSel] = 1'b1;
        end
    end

    // State registers; reset wipes data and all outstanding reservations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // One read port: {busy, data} for a select, with optional forwarding.
    function automatic logic [DATA_W:0] read_port(input logic [2:0] sel);
        logic [DATA_W-1:0] data;
        logic              busy;
        data = regs_q[sel];
        busy = busy_q[sel];
`ifdef REGFILE_BYPASS_EN
        if (bus.writeEn && bus.writeRegSel == sel) begin
            data = bus.writeData;
            busy = bus.issueEn && bus.issueRegSel == sel;
        end
`endif
        return {busy, data};
    endfunction

    // Read port 1, combinational.
    always_comb begin
        {bus.read1Busy, bus.read1Data} = read_port(bus.read1RegSel);
    end

    // Read port 2, combinational.
    always_comb begin
        {bus.read2Busy, bus.read2Data} = read_port(bus.read2RegSel);
    end

    assign bus.err = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized scoreboard bench for regfile_scoreboard. A stimulus process
// drives one transaction per cycle and pushes the expected port values from a
// simple array model; a monitor pops and compares on each falling edge.
module tb_regfile_scoreboard;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(DW)) bus ();

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] d1;
        logic          b1;
        logic [DW-1:0] d2;
        logic          b2;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural registers, reservations, pending err.
    logic [DW-1:0] m_regs [8];
    bit            m_busy [8];
    bit            m_err;
    bit            m_valid = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are settled mid-cycle; compare against the oldest entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("read1Data", bus.read1Data, e.d1);
            chk("read1Busy", {15'd0, bus.read1Busy}, {15'd0, e.b1});
            chk("read2Data", bus.read2Data, e.d2);
            chk("read2Busy", {15'd0, bus.read2Busy}, {15'd0, e.b2});
            chk("err",       {15'd0, bus.err},       {15'd0, e.err});
        end
    end

    function automatic logic [DW:0] model_read(input logic [2:0] sel, input bit we,
                                               input logic [2:0] wsel, input logic [DW-1:0] wdata,
                                               input bit ie, input logic [2:0] isel);
        logic [DW-1:0] d;
        bit            b;
        d = m_regs[sel];
        b = m_busy[sel];
`ifdef REGFILE_BYPASS_EN
        if (we && wsel == sel) begin
            d = wdata;
            b = ie && isel == sel;
        end
`else
        if (we && ie && wsel == isel) d = d;  // no forwarding in this build
`endif
        return {b, d};
    endfunction

    // One cycle: drive after the edge, queue the expected view, advance model.
    task automatic cycle(input bit rst, input bit we, input logic [2:0] wsel,
                         input logic [DW-1:0] wdata, input bit ie, input logic [2:0] isel,
                         input logic [2:0] r1, input logic [2:0] r2);
        exp_t e;
        logic [DW:0] p;
        @(posedge clk);
        #1;
        rst_n           = !rst;
        bus.writeEn     = we;
        bus.writeRegSel = wsel;
        bus.writeData   = wdata;
        bus.issueEn     = ie;
        bus.issueRegSel = isel;
        bus.read1RegSel = r1;
        bus.read2RegSel = r2;
        if (m_valid) begin
            p = model_read(r1, we, wsel, wdata, ie, isel);
            e.d1 = p[DW-1:0]; e.b1 = p[DW];
            p = model_read(r2, we, wsel, wdata, ie, isel);
            e.d2 = p[DW-1:0]; e.b2 = p[DW];
            e.err = m_err;
            exp_q.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 0;
            end
            m_err   = 0;
            m_valid = 1;
        end else begin
            m_err = we && !m_busy[wsel];
            if (we) begin
                m_regs[wsel] = wdata;
                m_busy[wsel] = 0;
            end
            if (ie) m_busy[isel] = 1;
        end
    endtask

    task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
        cycle(0, 0, 3'd0, '0, 0, 3'd0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.writeEn = 0; bus.writeRegSel = 0; bus.writeData = 0;
        bus.issueEn = 0; bus.issueRegSel = 0;
        bus.read1RegSel = 0; bus.read2RegSel = 0;

        cycle(1, 0, 0, '0, 0, 0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0, 0, 0);
        // Reset state on every register, both ports.
        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

        // Reserved write-back of r3 observed on port 1.
        cycle(0, 0, 0, '0, 1, 3'd3, 3'd3, 3'd3);
        cycle(0, 1, 3'd3, 16'hBEEF, 0, 0, 3'd3, 3'd0);
        idle(3'd3, 3'd3);
        // Unreserved write-back of r5.
        cycle(0, 1, 3'd5, 16'h1234, 0, 0, 3'd5, 3'd5);
        idle(3'd5, 3'd5);
        idle(3'd5, 3'd0);
        // r2 busy, then issue and write it together.
        cycle(0, 0, 0, '0, 1, 3'd2, 3'd2, 3'd2);
        cycle(0, 1, 3'd2, 16'h00FF, 1, 3'd2, 3'd2, 3'd2);
        idle(3'd2, 3'd2);
        // Reservations lost across reset.
        cycle(0, 0, 0, '0, 1, 3'd1, 3'd1, 3'd6);
        cycle(0, 0, 0, '0, 1, 3'd6, 3'd1, 3'd6);
        idle(3'd1, 3'd6);
        cycle(1, 0, 0, '0, 0, 0, 3'd1, 3'd6);
        cycle(0, 1, 3'd6, 16'h5555, 0, 0, 3'd6, 3'd1);
        idle(3'd6, 3'd1);
        // Both ports on one register.
        cycle(0, 1, 3'd4, 16'hA5A5, 0, 0, 3'd4, 3'd4);
        idle(3'd4, 3'd4);
        // Back-to-back unreserved write-backs.
        cycle(0, 1, 3'd0, 16'h1111, 0, 0, 3'd0, 3'd7);
        cycle(0, 1, 3'd7, 16'h7777, 0, 0, 3'd0, 3'd7);
        idle(3'd0, 3'd7);
        // Issue and write different registers in one cycle.
        cycle(0, 0, 0, '0, 1, 3'd5, 3'd5, 3'd5);
        cycle(0, 1, 3'd5, 16'hCAFE, 1, 3'd6, 3'd5, 3'd6);
        idle(3'd5, 3'd6);

        // Random traffic, biased towards issue/write-back and rare resets.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle(3'd0, 3'd1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001: Parameter DATA_W, default 16, register and write-data width in bits.
REQ-002: Parameter NUM_REGS, fixed 8, register count; select width 3.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst_n  input  1  reset, synchronous and active-low.
REQ-005: writeEn  input  1  write-back valid; commits writeData to writeRegSel.
REQ-006: writeRegSel  input  3  write-back destination register.
REQ-007: writeData  input  DATA_W  write-back data driven by the write-back stage.
REQ-008: issueEn  input  1  decode issued an instruction that will write issueRegSel.
REQ-009: issueRegSel  input  3  destination reserved at issue.
REQ-010: read1RegSel  input  3  read port 1 select.
REQ-011: read2RegSel  input  3  read port 2 select.
REQ-012: read1Data  output  DATA_W  read port 1 data.
REQ-013: read2Data  output  DATA_W  read port 2 data.
REQ-014: read1Busy  output  1  register on port 1 has an outstanding producer.
REQ-015: read2Busy  output  1  register on port 2 has an outstanding producer.
REQ-016: err  output  1  registered one-cycle pulse flagging an unreserved write-back.

Function
REQ-017: The block SHALL hold 8 DATA_W-bit registers and an 8-bit busy vector; register 0 is an ordinary writable register.
REQ-018: On a rising edge with writeEn=1, register[writeRegSel] SHALL take writeData; one write per cycle.
REQ-019: Read ports SHALL be combinational from the register array and busy vector, zero-cycle latency; both ports may select the same register.
REQ-020: On a rising edge, issueEn=1 SHALL set busy[issueRegSel]; writeEn=1 SHALL clear busy[writeRegSel].
REQ-021: On simultaneous issueEn and writeEn to the same register, busy SHALL end the cycle set (new producer wins) and data SHALL still be written.
REQ-022: Simultaneous issueEn and writeEn to different registers SHALL update both bits independently.
REQ-023: Issue to an already-busy register SHALL keep busy set; no error, no counting (in-order completion).
REQ-024: err SHALL be 1 for exactly the cycle after an edge where writeEn=1 and busy[writeRegSel]=0 before that edge; data is still written.
REQ-025: Back-to-back unreserved write-backs SHALL produce err high on consecutive cycles.

Reset
REQ-026: While rst_n=0 at a rising edge, all registers SHALL become 0, busy SHALL become 0, err SHALL become 0; writeEn and issueEn SHALL be ignored that edge.
REQ-027: After reset, read1Data=read2Data=0 and read1Busy=read2Busy=0 until the first write or issue.
REQ-028: Reset asserted mid-operation SHALL discard all outstanding reservations; a later write-back to a formerly busy register SHALL raise err.

Configuration
REQ-029: Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-030: With REGFILE_BYPASS_EN defined, when writeEn=1 and writeRegSel equals a port's select, that port SHALL output writeData in the same cycle, and its busy output SHALL be 0 unless issueEn=1 with issueRegSel equal to that select.
REQ-031: Without REGFILE_BYPASS_EN, read data and busy SHALL reflect only state stored at the previous edge; a same-cycle write becomes visible one cycle later.

Verification
REQ-032: Reset, then read r0..r7 on both ports -> all data 0x0000, busy 0, err 0.
REQ-033: Issue r3; next cycle write r3=0xBEEF with read1RegSel=3 -> bypass: read1Data=0xBEEF, read1Busy=0 same cycle; no bypass: 0x0000/busy 1 that cycle, 0xBEEF/busy 0 next; err stays 0.
REQ-034: Write r5=0x1234 with no prior issue -> err=1 exactly one cycle after, r5 reads 0x1234.
REQ-035: Issue r2 and write r2=0x00FF in the same cycle with r2 previously busy -> busy[2] remains 1, r2=0x00FF, err 0.
REQ-036: Issue r1, r6; assert rst_n=0 one cycle; then write r6=0x5555 -> err=1, busy all 0, r6=0x5555.
REQ-037: read1RegSel=read2RegSel=4 after r4=0xA5A5 written -> both ports 0xA5A5.
